// File: rtl/game_ctrl_if.sv
// game_ctrl_if: frame/start/collide/landed inputs and game status outputs of the
// frog-and-meteors game controller; master drives the inputs, slave is game_ctrl.
interface game_ctrl_if #(
    parameter int SPR_CNT = 5,
    parameter int SCORE_W = 8
);
    logic               frame;
    logic               start;
    logic               collide;
    logic [SPR_CNT-1:0] landed;
    logic [1:0]         state;
    logic               run;
    logic               frog_dead;
    logic [SCORE_W-1:0] score;
    logic [2:0]         speed;
    logic [SCORE_W-1:0] hiscore;

    modport master (
        output frame, start, collide, landed,
        input  state, run, frog_dead, score, speed, hiscore
    );

    modport slave (
        input  frame, start, collide, landed,
        output state, run, frog_dead, score, speed, hiscore
    );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: game FSM (ATTRACT/PLAY/DYING/OVER), scoring, speed levels, death countdown.
// Define GAME_CTRL_HISCORE_EN to keep a best-score register; otherwise hiscore is tied to 0.
module game_ctrl #(
    parameter int SPR_CNT    = 5,
    parameter int SCORE_W    = 8,
    parameter int LEVEL_PTS  = 10,
    parameter int SPEED_MIN  = 1,
    parameter int SPEED_MAX  = 4,
    parameter int DIE_FRAMES = 120
) (
    input  logic       clk_pix,
    input  logic       rst_n,
    game_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ATTRACT = 2'd0,
        PLAY    = 2'd1,
        DYING   = 2'd2,
        OVER    = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(SPR_CNT + 1);
    localparam int SUM_W = SCORE_W + 1;
    localparam int PTS_W = $clog2(LEVEL_PTS + SPR_CNT + 1);
    localparam int DIE_W = (DIE_FRAMES > 1) ? $clog2(DIE_FRAMES) : 1;
    localparam logic [2:0]       SPD_MIN  = 3'(SPEED_MIN);
    localparam logic [2:0]       SPD_MAX  = 3'(SPEED_MAX);
    localparam logic [PTS_W-1:0] PTS_STEP = PTS_W'(LEVEL_PTS);
    localparam logic [DIE_W-1:0] DIE_LOAD = DIE_W'(DIE_FRAMES - 1);

    state_t             state_q;
    logic               run_q;
    logic               frog_dead_q;
    logic               hit_q;
    logic               start_q;
    logic [SCORE_W-1:0] score_q;
    logic [2:0]         speed_q;
    logic [PTS_W-1:0]   pts_q;
    logic [DIE_W-1:0]   die_cnt_q;

    logic               start_edge;
    logic               enter_over;
    logic [CNT_W-1:0]   land_cnt;
    logic [SUM_W-1:0]   score_sum;
    logic [SCORE_W-1:0] score_sat;
    logic [PTS_W-1:0]   pts_sum;
    logic               level_up;
    logic [PTS_W-1:0]   pts_next;
    logic [2:0]         speed_next;

    assign start_edge = bus.start & ~start_q;
    assign enter_over = (state_q == DYING) && bus.frame && (die_cnt_q == '0);

    always_comb begin
        // NOTE: every always_comb output is assigned a default first, so no path can infer a latch.
        land_cnt = '0;
        for (int i = 0; i < SPR_CNT; i++) begin
            land_cnt = land_cnt + CNT_W'(bus.landed[i]);
        end
        score_sum  = {1'b0, score_q} + SUM_W'(land_cnt);
        score_sat  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        pts_sum    = pts_q + PTS_W'(land_cnt);
        level_up   = (pts_sum >= PTS_STEP);
        pts_next   = level_up ? (pts_sum - PTS_STEP) : pts_sum;
        speed_next = (level_up && (speed_q < SPD_MAX)) ? (speed_q + 3'd1) : speed_q;
    end

    // start_q resets high so a start button held through reset never looks like a press.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ATTRACT;
            run_q       <= 1'b0;
            frog_dead_q <= 1'b0;
            hit_q       <= 1'b0;
            start_q     <= 1'b1;
            score_q     <= '0;
            speed_q     <= SPD_MIN;
            pts_q       <= '0;
            die_cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            start_q <= bus.start;
            case (state_q)
                ATTRACT, OVER: begin
                    if (start_edge) begin
                        state_q     <= PLAY;
                        run_q       <= 1'b1;
                        frog_dead_q <= 1'b0;
                        hit_q       <= 1'b0;
                        score_q     <= '0;
                        speed_q     <= SPD_MIN;
                        pts_q       <= '0;
                    end
                end
                PLAY: begin
                    if (bus.frame) begin
                        score_q <= score_sat;
                        pts_q   <= pts_next;
                        speed_q <= speed_next;
                    end
                    // The frame that ends the game still scores its landings above.
                    if (bus.frame && hit_q) begin
                        state_q     <= DYING;
                        run_q       <= 1'b0;
                        frog_dead_q <= 1'b1;
                        hit_q       <= 1'b0;
                        die_cnt_q   <= DIE_LOAD;
                    end else if (bus.collide) begin
                        hit_q <= 1'b1;
                    end
                end
                DYING: begin
                    if (enter_over) begin
                        state_q     <= OVER;
                        frog_dead_q <= 1'b0;
                    end else if (bus.frame) begin
                        die_cnt_q <= die_cnt_q - DIE_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.state     = state_q;
    assign bus.run       = run_q;
    assign bus.frog_dead = frog_dead_q;
    assign bus.score     = score_q;
    assign bus.speed     = speed_q;

`ifdef GAME_CTRL_HISCORE_EN
    logic [SCORE_W-1:0] hiscore_q;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            hiscore_q <= '0;
        end else if (enter_over && (score_q > hiscore_q)) begin
            hiscore_q <= score_q;
        end
    end

    assign bus.hiscore = hiscore_q;
`else
    assign bus.hiscore = '0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed game scenarios plus random play, every cycle compared
// against a game-rule reference model (total landings, frames spent dying).
module tb_game_ctrl;
    localparam int SPR_CNT    = 5;
    localparam int SCORE_W    = 8;
    localparam int LEVEL_PTS  = 10;
    localparam int SPEED_MIN  = 1;
    localparam int SPEED_MAX  = 4;
    localparam int DIE_FRAMES = 120;
    localparam int SCORE_MAX  = (1 << SCORE_W) - 1;

    logic clk_pix = 1'b0;
    logic rst_n   = 1'b0;

    game_ctrl_if #(.SPR_CNT(SPR_CNT), .SCORE_W(SCORE_W)) bus ();

    game_ctrl #(
        .SPR_CNT(SPR_CNT), .SCORE_W(SCORE_W), .LEVEL_PTS(LEVEL_PTS),
        .SPEED_MIN(SPEED_MIN), .SPEED_MAX(SPEED_MAX), .DIE_FRAMES(DIE_FRAMES)
    ) dut (
        .clk_pix(clk_pix),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 clk_pix = ~clk_pix;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: game phase, landings counted this game, frames seen while dying.
    int m_phase;
    int m_total;
    int m_dying_frames;
    int m_hi;
    bit m_hit;
    bit m_start_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_score();
        return (m_total > SCORE_MAX) ? SCORE_MAX : m_total;
    endfunction

    function automatic int exp_speed();
        int s;
        s = SPEED_MIN + m_total / LEVEL_PTS;
        return (s > SPEED_MAX) ? SPEED_MAX : s;
    endfunction

    task automatic model_reset();
        m_phase        = 0;
        m_total        = 0;
        m_dying_frames = 0;
        m_hi           = 0;
        m_hit          = 1'b0;
        m_start_prev   = 1'b1;
    endtask

    task automatic model_step(input bit f, input bit s, input bit c, input logic [SPR_CNT-1:0] l);
        bit pressed;
        pressed      = s && !m_start_prev;
        m_start_prev = s;
        case (m_phase)
            0, 3: if (pressed) begin
                m_phase = 1;
                m_total = 0;
                m_hit   = 1'b0;
            end
            1: begin
                if (f) m_total += $countones(l);
                if (f && m_hit) begin
                    m_phase        = 2;
                    m_hit          = 1'b0;
                    m_dying_frames = 0;
                end else if (c) begin
                    m_hit = 1'b1;
                end
            end
            default: if (f) begin
                m_dying_frames++;
                if (m_dying_frames == DIE_FRAMES) begin
                    m_phase = 3;
`ifdef GAME_CTRL_HISCORE_EN
                    if (exp_score() > m_hi) m_hi = exp_score();
`endif
                end
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"},     32'(bus.state),     32'(m_phase));
        check({tag, ".run"},       32'(bus.run),       32'(m_phase == 1));
        check({tag, ".frog_dead"}, 32'(bus.frog_dead), 32'(m_phase == 2));
        check({tag, ".score"},     32'(bus.score),     32'(exp_score()));
        check({tag, ".speed"},     32'(bus.speed),     32'(exp_speed()));
        check({tag, ".hiscore"},   32'(bus.hiscore),   32'(m_hi));
    endtask

    task automatic tick(input string tag, input bit f, input bit s, input bit c,
                        input logic [SPR_CNT-1:0] l);
        bus.frame   = f;
        bus.start   = s;
        bus.collide = c;
        bus.landed  = l;
        model_step(f, s, c, l);
        @(posedge clk_pix);
        #1;
        check_all(tag);
    endtask

    // A frame every other cycle, with start held at level s.
    task automatic frames(input string tag, input int n, input bit s, input logic [SPR_CNT-1:0] l);
        for (int i = 0; i < n; i++) begin
            tick(tag, 1'b1, s, 1'b0, l);
            tick(tag, 1'b0, s, 1'b0, '0);
        end
    endtask

    task automatic play_game(input string tag, input int fives, input int twos);
        tick({tag, "_rel"}, 1'b0, 1'b0, 1'b0, '0);
        tick({tag, "_press"}, 1'b0, 1'b1, 1'b0, '0);
        tick({tag, "_rel2"}, 1'b0, 1'b0, 1'b0, '0);
        frames({tag, "_five"}, fives, 1'b0, 5'b11111);
        frames({tag, "_two"}, twos, 1'b0, 5'b00011);
        tick({tag, "_hit"}, 1'b0, 1'b0, 1'b1, '0);
        frames({tag, "_die"}, 1, 1'b0, '0);
        frames({tag, "_dying"}, DIE_FRAMES, 1'b0, '0);
    endtask

    initial begin
        bus.frame   = 1'b0;
        bus.start   = 1'b0;
        bus.collide = 1'b0;
        bus.landed  = '0;
        model_reset();
        #12;
        check_all("in_reset");
        #5 rst_n = 1'b1;

        tick("idle", 1'b0, 1'b0, 1'b0, '0);
        tick("idle_collide", 1'b0, 1'b0, 1'b1, '1);
        tick("idle_frame", 1'b1, 1'b0, 1'b0, '1);
        tick("start_press", 1'b0, 1'b1, 1'b0, '0);
        tick("start_rel", 1'b0, 1'b0, 1'b0, '0);
        tick("nonframe_landed", 1'b0, 1'b0, 1'b0, '1);

        // Game A: level-up at 10 points, death scored with its frame, held start ignored.
        frames("three_full", 3, 1'b0, 5'b11111);
        tick("collide_mid", 1'b0, 1'b0, 1'b1, '0);
        tick("after_collide", 1'b0, 1'b0, 1'b0, '0);
        tick("start_in_play", 1'b0, 1'b1, 1'b0, '0);
        tick("death_frame", 1'b1, 1'b1, 1'b0, 5'b00011);
        for (int i = 0; i < DIE_FRAMES; i++) begin
            tick("dying_frame", 1'b1, 1'b1, 1'b1, '1);
            tick("dying_gap", 1'b0, 1'b1, 1'b1, '0);
        end
        for (int i = 0; i < 4; i++) tick("over_held", 1'b0, 1'b1, 1'b0, '0);
        tick("over_release", 1'b0, 1'b0, 1'b0, '0);
        tick("replay_press", 1'b0, 1'b1, 1'b0, '0);

        // Game B: saturate the score, then reset asynchronously mid-death.
        frames("saturate", 60, 1'b1, 5'b11111);
        tick("b_hit", 1'b0, 1'b1, 1'b1, '0);
        frames("b_die", 10, 1'b1, '0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(posedge clk_pix);
        #1;
        check_all("reset_hold");
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick("start_thru_reset", 1'b0, 1'b1, 1'b0, '0);

        // Games C and D: 12 then 7 points.
        play_game("game12", 2, 1);
        play_game("game7", 1, 1);

        for (int i = 0; i < 5000; i++) begin
            tick("random",
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 40) == 0,
                 SPR_CNT'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 The block SHALL have parameter SPR_CNT, default 5, meaning the number of meteor lanes reporting landings.
REQ-002 The block SHALL have parameter SCORE_W, default 8, meaning the score width in bits.
REQ-003 The block SHALL have parameter LEVEL_PTS, default 10, meaning the points needed per speed step.
REQ-004 The block SHALL have parameter SPEED_MIN, default 1, meaning the meteor speed after game start.
REQ-005 The block SHALL have parameter SPEED_MAX, default 4, meaning the meteor speed ceiling.
REQ-006 The block SHALL have parameter DIE_FRAMES, default 120, meaning the frames spent in DYING.
REQ-007 The block SHALL have port clk_pix, input, 1 bit: pixel clock, the only clock.
REQ-008 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 The block SHALL have port frame, input, 1 bit: one-cycle pulse at frame start.
REQ-010 The block SHALL have port start, input, 1 bit: debounced start button, as a level.
REQ-011 The block SHALL have port collide, input, 1 bit: frog/obstacle pixel overlap, which may assert on any cycle.
REQ-012 The block SHALL have port landed, input, SPR_CNT bits: per-meteor wrap flags, valid only on frame cycles.
REQ-013 The block SHALL have port state, output, 2 bits: ATTRACT=0, PLAY=1, DYING=2, OVER=3.
REQ-014 The block SHALL have port run, output, 1 bit: movement enable for the frog and meteors.
REQ-015 The block SHALL have port frog_dead, output, 1 bit: frog-falls animation enable.
REQ-016 The block SHALL have port score, output, SCORE_W bits: current score.
REQ-017 The block SHALL have port speed, output, 3 bits: meteor pixels per frame.
REQ-018 The block SHALL have port hiscore, output, SCORE_W bits: best score.

Function
REQ-019 All outputs SHALL be registered, and the effects of a frame cycle SHALL be visible on the following cycle.
REQ-020 start SHALL be edge-detected internally; only a 0->1 transition counts, so a held start SHALL NOT retrigger.
REQ-021 In ATTRACT, a start edge SHALL move the FSM to PLAY and, on that same transition, clear score, set speed=SPEED_MIN and clear the level-points counter.
REQ-022 In PLAY, run=1; a collide on any cycle SHALL set a sticky hit flag.
REQ-023 In PLAY, on frame, score SHALL increase by popcount(landed) and saturate at 2^SCORE_W-1.
REQ-024 Level-points counter: on frame, pts+popcount >= LEVEL_PTS SHALL subtract LEVEL_PTS and increment speed, saturating at SPEED_MAX; at most one step per frame.
REQ-025 In PLAY, on frame with hit set, the FSM SHALL go to DYING, load die_cnt=DIE_FRAMES-1, and clear hit; the same frame's landings SHALL still be scored first.
REQ-026 In DYING: run=0, frog_dead=1, score frozen; die_cnt SHALL decrement on each frame; a frame with die_cnt=0 SHALL move the FSM to OVER.
REQ-027 In OVER: run=0, frog_dead=0, score held; a start edge SHALL go directly to PLAY with the REQ-021 clears.
REQ-028 A start edge in PLAY or DYING SHALL be ignored and not queued.
REQ-029 collide outside PLAY SHALL be ignored; the hit flag SHALL be cleared on every entry to PLAY.
REQ-030 landed outside PLAY, or landed on a non-frame cycle, SHALL be ignored.
REQ-031 speed SHALL stay within SPEED_MIN..SPEED_MAX at all times.

Reset
REQ-032 rst_n low SHALL asynchronously force: state=ATTRACT, run=0, frog_dead=0, score=0, speed=SPEED_MIN, hiscore=0, hit=0, die_cnt=0, pts=0, and the start-edge history=1, so that a start held through reset SHALL NOT trigger.
REQ-033 Reset asserted mid-game SHALL abandon the game immediately, with no OVER pass.
REQ-034 The deassertion of rst_n SHALL be consumed synchronously to clk_pix.

Configuration
REQ-035 Macro GAME_CTRL_HISCORE_EN, when defined, SHALL make hiscore load score on entry to OVER if score > hiscore, held otherwise.
REQ-036 When GAME_CTRL_HISCORE_EN is undefined, hiscore SHALL be constant 0 and no hiscore register SHALL exist.

Verification
REQ-037 Reset and start: release reset with start low, pulse start -> next cycle state=1, run=1, score=0, speed=1.
REQ-038 Scoring and level-up: in PLAY, 3 frames with landed=5'b11111 -> score=15, speed=2, pts=5; continue to score 255 -> score saturates at 255, speed stays 4.
REQ-039 Death sequence: collide pulse mid-frame, then a frame with landed=5'b00011 -> score+2, state=2 next cycle, frog_dead=1; after 120 frames -> state=3, run=0.
REQ-040 Held start and replay: start held high from PLAY through OVER -> no retrigger; release, then press -> state=1, score=0, speed=1.
REQ-041 Async reset in DYING: rst_n low between clock edges -> outputs reset values immediately, without waiting for a clock edge.
REQ-042 With GAME_CTRL_HISCORE_EN: games scoring 12 then 7 -> hiscore=12 after each OVER; without the macro -> hiscore=0 throughout.
